// File: rtl/rbot_pkg.sv
// Shared definitions for the rbot move path: face encoding, the packed move word
// and the move_sequencer state encoding.
package rbot_pkg;

    localparam int NUM_FACES = 6;

    localparam logic [2:0] FACE_U = 3'd0;
    localparam logic [2:0] FACE_D = 3'd1;
    localparam logic [2:0] FACE_L = 3'd2;
    localparam logic [2:0] FACE_R = 3'd3;
    localparam logic [2:0] FACE_F = 3'd4;
    localparam logic [2:0] FACE_B = 3'd5;

    // One queued move; this is also the FIFO word layout {face, dir, half}.
    typedef struct packed {
        logic [2:0] face;
        logic       dir;
        logic       half;
    } move_t;

    localparam int MOVE_W = $bits(move_t);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_FIRE  = 3'd2,
        S_ARM   = 3'd3,
        S_WAIT  = 3'd4,
        S_GAP   = 3'd5,
        S_FAULT = 3'd6
    } seq_state_t;

    // One-hot driver select for a face; invalid faces (6, 7) give all zeros.
    function automatic logic [NUM_FACES-1:0] face_onehot(input logic [2:0] face);
        logic [NUM_FACES-1:0] one;
        one = {{(NUM_FACES-1){1'b0}}, 1'b1};
        return one << face;
    endfunction

endpackage

// File: rtl/move_fifo.sv
// Show-ahead FIFO for queued moves: dout always presents the oldest entry.
// A push while full is accepted only when a pop happens in the same cycle.
module move_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointer and fill-level bookkeeping; reset empties the queue.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/move_sequencer.sv
// Runs queued cube-face moves one at a time on six stepper drivers:
// set direction, let it settle, fire a one-cycle start, wait for done, hold a gap.
// Optional watchdog in WAIT is built when MOVE_TIMEOUT_EN is defined.
module move_sequencer
    import rbot_pkg::*;
#(
    parameter int FIFO_DEPTH    = 8,
    parameter int STEPS_QUARTER = 50,
    parameter int DIR_SETUP     = 4,
    parameter int MOVE_GAP      = 16
`ifdef MOVE_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC   = 1 << 24
`endif
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 move_valid,
    output logic                 move_ready,
    input  logic [2:0]           move_face,
    input  logic                 move_dir,
    input  logic                 move_half,
    output logic [NUM_FACES-1:0] drv_start,
    output logic [7:0]           drv_steps,
    output logic [NUM_FACES-1:0] drv_dir,
    input  logic [NUM_FACES-1:0] drv_done,
    output logic                 busy,
    output logic                 bad_move,
    output logic                 fault,
    output logic [15:0]          moves_done
);

    // GAP and SETUP never collapse to zero cycles.
    localparam int GAP_LAST = (MOVE_GAP > 0) ? MOVE_GAP - 1 : 0;

    seq_state_t           state;
    seq_state_t           state_next;
    move_t                move_in;
    move_t                head;
    move_t                move_reg;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic [15:0]          cnt;
    logic [NUM_FACES-1:0] sel;
    logic                 done_hit;

    assign move_in  = '{face: move_face, dir: move_dir, half: move_half};
    assign push     = move_valid && move_ready;
    assign sel      = face_onehot(move_reg.face);
    assign done_hit = |(drv_done & sel);

    move_fifo #(
        .WIDTH (MOVE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     (move_in),
        .dout    (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

`ifdef MOVE_TIMEOUT_EN
    logic [23:0] wait_cnt;

    // Watchdog counts cycles spent in WAIT; restarts on every other state.
    always_ff @(posedge clock) begin
        if (!reset_n || state != S_WAIT) wait_cnt <= '0;
        else                             wait_cnt <= wait_cnt + 1'b1;
    end

    assign fault      = (state == S_FAULT);
    assign move_ready = !fifo_full && (state != S_FAULT);
`else
    assign fault      = 1'b0;
    assign move_ready = !fifo_full;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    // Next-state logic, queue pop and the invalid-face pulse.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        bad_move   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head.face > FACE_B) bad_move   = 1'b1;
                    else                    state_next = S_SETUP;
                end
            end
            S_SETUP: if (cnt == 16'(DIR_SETUP)) state_next = S_FIRE;
            S_FIRE:  state_next = S_ARM;
            S_ARM:   state_next = S_WAIT;
            S_WAIT: begin
                if (done_hit) state_next = S_GAP;
`ifdef MOVE_TIMEOUT_EN
                else if (wait_cnt == 24'(TIMEOUT_CYC - 1)) state_next = S_FAULT;
`endif
            end
            S_GAP:   if (cnt >= 16'(GAP_LAST)) state_next = S_IDLE;
`ifdef MOVE_TIMEOUT_EN
            S_FAULT: state_next = S_FAULT;
`endif
            default: state_next = S_IDLE;
        endcase
    end

    // Phase counter: zero on the first cycle of every state, then counts up.
    always_ff @(posedge clock) begin
        if (!reset_n || state_next != state) cnt <= '0;
        else                                 cnt <= cnt + 1'b1;
    end

    // Latch the popped move, drive the selected face direction, count completions.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            move_reg   <= '0;
            drv_dir    <= '0;
            moves_done <= '0;
        end else begin
            if (pop) move_reg <= head;
            if (state == S_SETUP) drv_dir <= (drv_dir & ~sel) | (sel & {NUM_FACES{move_reg.dir}});
            if (state == S_WAIT && done_hit) moves_done <= moves_done + 1'b1;
        end
    end

    // Driver fan-out: start and step count exist only during FIRE.
    always_comb begin
        drv_start = '0;
        drv_steps = '0;
        if (state == S_FIRE) begin
            drv_start = sel;
            drv_steps = move_reg.half ? 8'(2 * STEPS_QUARTER) : 8'(STEPS_QUARTER);
        end
    end

    assign busy = !fifo_empty || (state != S_IDLE);

endmodule

// File: tb/tb_move_sequencer.sv
// Directed self-checking bench for move_sequencer (default parameters).
// Define MOVE_TIMEOUT_EN to exercise the watchdog with TIMEOUT_CYC=100.
module tb_move_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        move_valid;
    logic        move_ready;
    logic [2:0]  move_face;
    logic        move_dir;
    logic        move_half;
    logic [5:0]  drv_start;
    logic [7:0]  drv_steps;
    logic [5:0]  drv_dir;
    logic [5:0]  drv_done;
    logic        busy;
    logic        bad_move;
    logic        fault;
    logic [15:0] moves_done;

    int         checks = 0;
    int         errors = 0;
    logic [5:0] exp_dir;

    always #5 clock = ~clock;

    move_sequencer #(
        .FIFO_DEPTH    (8),
        .STEPS_QUARTER (50),
        .DIR_SETUP     (4),
        .MOVE_GAP      (16)
`ifdef MOVE_TIMEOUT_EN
        ,
        .TIMEOUT_CYC   (100)
`endif
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .move_valid (move_valid),
        .move_ready (move_ready),
        .move_face  (move_face),
        .move_dir   (move_dir),
        .move_half  (move_half),
        .drv_start  (drv_start),
        .drv_steps  (drv_steps),
        .drv_dir    (drv_dir),
        .drv_done   (drv_done),
        .busy       (busy),
        .bad_move   (bad_move),
        .fault      (fault),
        .moves_done (moves_done)
    );

    // Advance one clock; sample/drive 1 time unit after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_move(input logic [2:0] f, input logic d, input logic h);
        move_face = f;
        move_dir  = d;
        move_half = h;
    endtask

    // Step until any drv_start bit is seen; cycles = -1 if the budget expires.
    task automatic wait_start(input int budget, output int cycles);
        cycles = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (drv_start != 6'b0) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        move_valid = 1'b0;
        drv_done   = 6'b0;
        set_move(3'd0, 1'b0, 1'b0);
        step();
        step();
        checks++;
        if (move_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_ready: got %b expected 1", move_ready);
        end
        checks++;
        if ({drv_start, drv_steps, drv_dir} !== 20'h0) begin
            errors++; $display("[TB] FAIL reset_drv: got start=%b steps=%0d dir=%b expected all 0", drv_start, drv_steps, drv_dir);
        end
        checks++;
        if ({busy, bad_move, fault} !== 3'b000) begin
            errors++; $display("[TB] FAIL reset_flags: got busy/bad/fault=%b expected 000", {busy, bad_move, fault});
        end
        checks++;
        if (moves_done !== 16'd0) begin
            errors++; $display("[TB] FAIL reset_count: got %0d expected 0", moves_done);
        end
        reset_n = 1'b1;
        exp_dir = 6'b0;
    endtask

    task automatic test_single_move();
        logic [5:0] dir_hist [32];
        int cyc;
        cyc = -1;
        move_valid = 1'b1;
        set_move(3'd2, 1'b1, 1'b0);
        step();
        move_valid = 1'b0;
        dir_hist[0] = drv_dir;
        for (int i = 1; i <= 20; i++) begin
            step();
            dir_hist[i] = drv_dir;
            if (drv_start != 6'b0) begin
                cyc = i;
                break;
            end
        end
        exp_dir[2] = 1'b1;
        checks++;
        if (cyc !== 6) begin
            errors++; $display("[TB] FAIL single_latency: got %0d expected 6", cyc);
        end
        if (cyc >= 5) begin
            checks++;
            if (dir_hist[cyc-4] !== 6'b000100 || dir_hist[cyc-5] !== 6'b000000) begin
                errors++; $display("[TB] FAIL single_dir_setup: got dir@-4=%b dir@-5=%b expected 000100/000000", dir_hist[cyc-4], dir_hist[cyc-5]);
            end
        end
        checks++;
        if (drv_start !== 6'b000100 || drv_steps !== 8'd50) begin
            errors++; $display("[TB] FAIL single_fire: got start=%b steps=%0d expected 000100/50", drv_start, drv_steps);
        end
        step();
        checks++;
        if (drv_start !== 6'b0 || drv_steps !== 8'd0) begin
            errors++; $display("[TB] FAIL single_arm: got start=%b steps=%0d expected 0/0", drv_start, drv_steps);
        end
        repeat (198) step();
        checks++;
        if (moves_done !== 16'd0 || busy !== 1'b1) begin
            errors++; $display("[TB] FAIL single_waiting: got count=%0d busy=%b expected 0/1", moves_done, busy);
        end
        drv_done = 6'b000100;
        step();
        drv_done = 6'b0;
        checks++;
        if (moves_done !== 16'd1) begin
            errors++; $display("[TB] FAIL single_count: got %0d expected 1", moves_done);
        end
        repeat (15) step();
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("[TB] FAIL gap_last_cycle: got busy=%b expected 1", busy);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("[TB] FAIL gap_end_idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_half_turn();
        int cyc;
        move_valid = 1'b1;
        set_move(3'd5, 1'b0, 1'b1);
        step();
        move_valid = 1'b0;
        wait_start(20, cyc);
        exp_dir[5] = 1'b0;
        checks++;
        if (cyc !== 6 || drv_start !== 6'b100000 || drv_steps !== 8'd100) begin
            errors++; $display("[TB] FAIL half_fire: got cyc=%0d start=%b steps=%0d expected 6/100000/100", cyc, drv_start, drv_steps);
        end
        checks++;
        if (drv_dir !== exp_dir) begin
            errors++; $display("[TB] FAIL half_dir: got %b expected %b", drv_dir, exp_dir);
        end
        step();
        step();
        drv_done = 6'b000001;
        step();
        drv_done = 6'b0;
        step();
        checks++;
        if (moves_done !== 16'd1 || busy !== 1'b1) begin
            errors++; $display("[TB] FAIL stray_done: got count=%0d busy=%b expected 1/1", moves_done, busy);
        end
        repeat (3) step();
        drv_done = 6'b100000;
        step();
        drv_done = 6'b0;
        checks++;
        if (moves_done !== 16'd2) begin
            errors++; $display("[TB] FAIL half_count: got %0d expected 2", moves_done);
        end
    endtask

    // Starts during the gap of the previous move so the queue fills before any pop.
    task automatic test_back_to_back();
        logic [2:0] faces [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
        logic       dirs  [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic       halfs [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        int         cyc;
        int         late_starts;
        logic [5:0] exp_sel;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (move_ready !== 1'b1) begin
                errors++; $display("[TB] FAIL fill_ready_%0d: got %b expected 1", i, move_ready);
            end
            move_valid = 1'b1;
            set_move(faces[i], dirs[i], halfs[i]);
            step();
        end
        set_move(3'd3, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (move_ready !== 1'b0) begin
                errors++; $display("[TB] FAIL full_ready_%0d: got %b expected 0", k, move_ready);
            end
            step();
        end
        move_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wait_start(60, cyc);
            exp_sel = 6'b000001 << faces[i];
            exp_dir[faces[i]] = dirs[i];
            checks++;
            if (cyc < 0 || drv_start !== exp_sel || drv_steps !== (halfs[i] ? 8'd100 : 8'd50) || drv_dir !== exp_dir) begin
                errors++; $display("[TB] FAIL order_%0d: got cyc=%0d start=%b steps=%0d dir=%b expected start=%b steps=%0d dir=%b",
                                   i, cyc, drv_start, drv_steps, drv_dir, exp_sel, halfs[i] ? 100 : 50, exp_dir);
            end
            step();
            step();
            drv_done = exp_sel;
            step();
            drv_done = 6'b0;
        end
        checks++;
        if (moves_done !== 16'd10) begin
            errors++; $display("[TB] FAIL fill_count: got %0d expected 10", moves_done);
        end
        late_starts = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (drv_start != 6'b0) late_starts++;
        end
        checks++;
        if (late_starts !== 0 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL ninth_dropped: got starts=%0d busy=%b expected 0/0", late_starts, busy);
        end
    endtask

    task automatic test_bad_move();
        int cyc;
        int bad_cnt;
        cyc     = -1;
        bad_cnt = 0;
        move_valid = 1'b1;
        set_move(3'd7, 1'b1, 1'b0);
        step();
        if (bad_move === 1'b1) bad_cnt++;
        set_move(3'd0, 1'b1, 1'b1);
        step();
        move_valid = 1'b0;
        if (bad_move === 1'b1) bad_cnt++;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (bad_move === 1'b1) bad_cnt++;
            if (drv_start != 6'b0) begin
                cyc = i;
                break;
            end
        end
        exp_dir[0] = 1'b1;
        checks++;
        if (bad_cnt !== 1) begin
            errors++; $display("[TB] FAIL bad_pulse: got %0d pulses expected 1", bad_cnt);
        end
        checks++;
        if (cyc !== 6 || drv_start !== 6'b000001 || drv_steps !== 8'd100 || drv_dir !== exp_dir) begin
            errors++; $display("[TB] FAIL after_bad: got cyc=%0d start=%b steps=%0d dir=%b expected 6/000001/100/%b", cyc, drv_start, drv_steps, drv_dir, exp_dir);
        end
        step();
        step();
        drv_done = 6'b000001;
        step();
        drv_done = 6'b0;
        checks++;
        if (moves_done !== 16'd11) begin
            errors++; $display("[TB] FAIL bad_count: got %0d expected 11", moves_done);
        end
        repeat (20) step();
    endtask

    task automatic test_reset_mid_move();
        int cyc;
        int starts;
        move_valid = 1'b1;
        set_move(3'd1, 1'b1, 1'b0);
        step();
        set_move(3'd2, 1'b0, 1'b0);
        step();
        set_move(3'd3, 1'b1, 1'b0);
        step();
        move_valid = 1'b0;
        wait_start(30, cyc);
        step();
        step();
        drv_done = 6'b000010;
        step();
        drv_done = 6'b0;
        wait_start(60, cyc);
        checks++;
        if (drv_start !== 6'b000100) begin
            errors++; $display("[TB] FAIL mid_second: got %b expected 000100", drv_start);
        end
        repeat (3) step();
        reset_n = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || drv_start !== 6'b0 || moves_done !== 16'd0 || move_ready !== 1'b1 || drv_dir !== 6'b0) begin
            errors++; $display("[TB] FAIL mid_reset: got busy=%b start=%b count=%0d ready=%b dir=%b expected 0/0/0/1/0",
                               busy, drv_start, moves_done, move_ready, drv_dir);
        end
        reset_n = 1'b1;
        exp_dir = 6'b0;
        starts  = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (drv_start != 6'b0) starts++;
        end
        checks++;
        if (starts !== 0 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL mid_after: got starts=%0d busy=%b expected 0/0", starts, busy);
        end
    endtask

    task automatic test_fault();
        int cyc;
`ifdef MOVE_TIMEOUT_EN
        int fault_cyc;
        int starts;
        fault_cyc = -1;
        move_valid = 1'b1;
        set_move(3'd4, 1'b1, 1'b0);
        step();
        set_move(3'd0, 1'b1, 1'b0);
        step();
        move_valid = 1'b0;
        wait_start(20, cyc);
        for (int i = 1; i <= 200; i++) begin
            step();
            if (fault === 1'b1) begin
                fault_cyc = i;
                break;
            end
        end
        checks++;
        if (fault_cyc !== 102) begin
            errors++; $display("[TB] FAIL fault_time: got %0d expected 102", fault_cyc);
        end
        checks++;
        if (move_ready !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("[TB] FAIL fault_flags: got ready=%b busy=%b expected 0/1", move_ready, busy);
        end
        starts = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (drv_start != 6'b0) starts++;
        end
        checks++;
        if (starts !== 0 || fault !== 1'b1) begin
            errors++; $display("[TB] FAIL fault_sticky: got starts=%0d fault=%b expected 0/1", starts, fault);
        end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        checks++;
        if (fault !== 1'b0 || move_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL fault_clear: got fault=%b ready=%b expected 0/1", fault, move_ready);
        end
`else
        int fault_seen;
        fault_seen = 0;
        move_valid = 1'b1;
        set_move(3'd4, 1'b1, 1'b0);
        step();
        move_valid = 1'b0;
        wait_start(20, cyc);
        for (int i = 0; i < 300; i++) begin
            step();
            if (fault !== 1'b0) fault_seen++;
        end
        checks++;
        if (fault_seen !== 0 || moves_done !== 16'd0 || busy !== 1'b1) begin
            errors++; $display("[TB] FAIL no_watchdog: got fault cycles=%0d count=%0d busy=%b expected 0/0/1", fault_seen, moves_done, busy);
        end
        drv_done = 6'b010000;
        step();
        drv_done = 6'b0;
        checks++;
        if (moves_done !== 16'd1) begin
            errors++; $display("[TB] FAIL long_wait_count: got %0d expected 1", moves_done);
        end
        repeat (20) step();
`endif
    endtask

    initial begin
        test_reset();
        test_single_move();
        test_half_turn();
        test_back_to_back();
        test_bad_move();
        test_reset_mid_move();
        test_fault();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

endmodule
